move_buffer_writer: RTL
=======================

# move_buffer_writer

Producer side of the move-buffer toggle-latch protocol. It accepts move commands from the command parser over a valid/ready handshake and stores each move's duration and payload in a slot of a circular buffer. It hands each filled slot to the DDA sequencer by flipping that slot's `stepready` latch. It counts the sequencer's `move_done` toggles to free slots, and it drives the duration and payload of the slot the sequencer currently indexes.

## Interface

Parameters:
- `buffer_bits`, 2: slot index width.
- `buffer_size`, 4: number of slots. Must equal 2**`buffer_bits`, because the sequencer's index wraps naturally.
- `move_duration_bits`, 32: width of the duration word.
- `payload_bits`, 64: width of the opaque per-move payload (axis increments, direction).

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `resetn`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  a command word is present.
- `in_ready`  out  1  the block can accept a command this cycle.
- `in_duration`  in  `move_duration_bits`  move length in DDA ticks.
- `in_payload`  in  `payload_bits`  move payload.
- `moveind`  in  `buffer_bits`  slot the sequencer is executing or loading.
- `move_done`  in  1  sequencer toggle, flipped once per completed move.
- `stepready`  out  `buffer_size`  per-slot toggle latches, one bit flipped per accepted move.
- `move_duration`  out  `move_duration_bits`  duration stored in slot `moveind`.
- `move_payload`  out  `payload_bits`  payload stored in slot `moveind`.
- `occupancy`  out  `buffer_bits`+1  number of slots pending, from 0 to `buffer_size`.
- `full`  out  1  `occupancy` == `buffer_size`.
- `empty`  out  1  `occupancy` == 0.
- `underflow_err`  out  1  sticky flag for a protocol violation.

## Operation
- State: `wr_ptr` (`buffer_bits`), `count` (`buffer_bits`+1), `stepready_r`, `move_done_q`, `underflow_err_r`, and two register arrays `dur_mem` and `pay_mem`, each `buffer_size` deep. No explicit FSM; per-slot state is encoded as `stepready` versus the sequencer's finished latch.
- `in_ready` = resetn & !full. It is combinational from registered `count` and has no dependence on `in_valid`.
- Accept = `in_valid` & `in_ready`. On an accept:
  - write `dur_mem[wr_ptr]` and `pay_mem[wr_ptr]`;
  - flip `stepready_r[wr_ptr]`;
  - increment `wr_ptr`, wrapping modulo `buffer_size`.
- Completion detect: `done_pulse` = `move_done` ^ `move_done_q`. `move_done_q` <= `move_done` every cycle.
- Count update:
  - accept & !done_pulse: +1.
  - done_pulse & !accept: -1.
  - both at once: unchanged.
  - neither: unchanged.
- Underflow: a `done_pulse` while `count`==0 and no accept sets `underflow_err` (sticky until reset). `count` stays at 0.
- `move_duration` and `move_payload` are combinational reads of the arrays at `moveind`.
- Slot safety: a slot is only written while it is free. The sequencer therefore never sees a slot's data change while that slot is pending.
- Payload and duration are passed through without interpretation. A duration of 0 is legal and denotes a one-tick move, per the sequencer's countdown.

## Timing
- Reset (resetn low at a rising edge) clears `stepready`, `wr_ptr`, `count`, `move_done_q` and `underflow_err` to 0. Array contents are don't-care.
- Reset values of outputs:
  - `in_ready`=0 while resetn is low, 1 in the first cycle after;
  - `empty`=1, `full`=0, `occupancy`=0.
- Reset mid-operation discards all pending moves. The sequencer shares `resetn`, so both sides' latches return to 0 together and the toggle parity stays consistent.
- Accept latency: a command accepted at edge N has `stepready` flipped and its data valid immediately after edge N. The sequencer can begin loading that slot in the cycle after N.
- Free latency: when `move_done` flips after edge N, `count` decrements at edge N+1. `in_ready` can rise in the cycle after N+1. A full buffer therefore exposes one bubble before the next accept.
- Back-to-back accepts sustain 1 per cycle until `full`.
- `wr_ptr` wraps from `buffer_size`-1 to 0, which matches the sequencer's `moveind` wrap.

## Test plan
- Reset: hold resetn low 3 cycles, then release. Required: `in_ready` 0 during reset and 1 after; `stepready`=0000; `occupancy`=0; `empty`=1; `underflow_err`=0.
- Fill: 4 back-to-back accepts with durations 10, 20, 30, 40. Required:
  - `stepready` steps 0001, 0011, 0111, 1111;
  - `full`=1 and `in_ready`=0 after the 4th accept;
  - a 5th `in_valid` (duration 50) is held and not accepted.
- Free and wrap: from full, toggle `move_done` with `moveind`=0. Required: `occupancy`=3 one edge later; `in_ready` rises; the held duration 50 is written to slot 0 and `stepready[0]` flips 1 to 0.
- Simultaneous events: `occupancy`=2, then accept and a `move_done` toggle in the same cycle. Required: `occupancy` stays 2, `wr_ptr` advances by 1, and one `stepready` bit flips.
- Read mux: after loading durations 10, 20, 30 with payloads A, B, C, sweep `moveind` over 0, 1, 2. Required: `move_duration`/`move_payload` read 10/A, 20/B, 30/C combinationally.
- Underflow: with the buffer empty, toggle `move_done`. Required: `underflow_err`=1 next cycle and `occupancy` stays 0. A later accept still works; only resetn clears the flag.

Source files
------------

// File: rtl/move_buffer_writer.sv
// rtl/move_buffer_writer.sv - producer side of the move-buffer toggle-latch protocol
module move_buffer_writer #(
  parameter int buffer_bits        = 2,
  parameter int buffer_size        = 4,
  parameter int move_duration_bits = 32,
  parameter int payload_bits       = 64
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [move_duration_bits-1:0] in_duration,
  input  logic [payload_bits-1:0]       in_payload,
  input  logic [buffer_bits-1:0]        moveind,
  input  logic                          move_done,
  output logic [buffer_size-1:0]        stepready,
  output logic [move_duration_bits-1:0] move_duration,
  output logic [payload_bits-1:0]       move_payload,
  output logic [buffer_bits:0]          occupancy,
  output logic                          full,
  output logic                          empty,
  output logic                          underflow_err
);

  localparam logic [buffer_bits:0]   size_c    = (buffer_bits+1)'(buffer_size);
  localparam logic [buffer_bits:0]   cnt_one   = 1;
  localparam logic [buffer_bits-1:0] ptr_one   = 1;

  logic [buffer_bits-1:0]        wr_ptr_q, wr_ptr_d;
  logic [buffer_bits:0]          count_q, count_d;
  logic [buffer_size-1:0]        stepready_q, stepready_d;
  logic                          move_done_q, move_done_d;
  logic                          underflow_err_q, underflow_err_d;
  logic [move_duration_bits-1:0] dur_mem_q [buffer_size];
  logic [move_duration_bits-1:0] dur_mem_d [buffer_size];
  logic [payload_bits-1:0]       pay_mem_q [buffer_size];
  logic [payload_bits-1:0]       pay_mem_d [buffer_size];

  logic accept;
  logic done_pulse;

  assign full          = (count_q == size_c);
  assign empty         = (count_q == '0);
  assign occupancy     = count_q;
  assign in_ready      = resetn & ~full;
  assign accept        = in_valid & in_ready;
  assign done_pulse    = move_done ^ move_done_q;
  assign stepready     = stepready_q;
  assign underflow_err = underflow_err_q;
  assign move_duration = dur_mem_q[moveind];
  assign move_payload  = pay_mem_q[moveind];

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    stepready_d     = stepready_q;
    move_done_d     = move_done;
    underflow_err_d = underflow_err_q;
    dur_mem_d       = dur_mem_q;
    pay_mem_d       = pay_mem_q;

    // in_ready guarantees the slot at wr_ptr is free, so pending data never changes
    if (accept) begin
      dur_mem_d[wr_ptr_q]   = in_duration;
      pay_mem_d[wr_ptr_q]   = in_payload;
      stepready_d[wr_ptr_q] = ~stepready_q[wr_ptr_q];
      wr_ptr_d              = wr_ptr_q + ptr_one;
    end

    if (accept && !done_pulse) begin
      count_d = count_q + cnt_one;
    end else if (done_pulse && !accept) begin
      if (count_q == '0) begin
        underflow_err_d = 1'b1;
      end else begin
        count_d = count_q - cnt_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q        <= '0;
      count_q         <= '0;
      stepready_q     <= '0;
      move_done_q     <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      stepready_q     <= stepready_d;
      move_done_q     <= move_done_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  // slot contents need no reset; stepready parity alone marks them pending
  always_ff @(posedge clk) begin
    dur_mem_q <= dur_mem_d;
    pay_mem_q <= pay_mem_d;
  end

endmodule
